rx_multi_dispatcher: RTL



---
 rtl/rx_dispatch_pkg.sv | 77 +++++++
 rtl/rx_dispatch_fifo.sv | 78 +++++++
 rtl/rx_multi_dispatcher.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rx_dispatch_pkg.sv
// Shared definitions for the RX multi-channel dispatcher.
//   - opcode field width and default position in the packet head
//   - route table entry type {vld, ch}
//   - reset-time default route table, keyed to the protocol opcode macros
// The opcode macros normally come from protocol_engine_def.vh. If that header
// has not been read before this file, the fallback values below are used.
// PKT_META_BUS_WIDTH is also given a fallback of 64 if it is undefined.

`ifndef PKT_META_BUS_WIDTH
`define PKT_META_BUS_WIDTH 64
`endif

`ifndef PROTOCOL_ENGINE_DEF_VH
`define OPC_SEND_FIRST                5'h00
`define OPC_SEND_MIDDLE               5'h01
`define OPC_SEND_LAST                 5'h02
`define OPC_SEND_LAST_IMM             5'h03
`define OPC_SEND_ONLY                 5'h04
`define OPC_SEND_ONLY_IMM             5'h05
`define OPC_RDMA_WRITE_FIRST          5'h06
`define OPC_RDMA_WRITE_MIDDLE         5'h07
`define OPC_RDMA_WRITE_LAST           5'h08
`define OPC_RDMA_WRITE_LAST_IMM       5'h09
`define OPC_RDMA_WRITE_ONLY           5'h0A
`define OPC_RDMA_WRITE_ONLY_IMM       5'h0B
`define OPC_RDMA_READ_REQUEST         5'h0C
`define OPC_RDMA_READ_RESPONSE_FIRST  5'h0D
`define OPC_RDMA_READ_RESPONSE_MIDDLE 5'h0E
`define OPC_RDMA_READ_RESPONSE_LAST   5'h0F
`define OPC_RDMA_READ_RESPONSE_ONLY   5'h10
`define OPC_ACKNOWLEDGE               5'h11
`endif

package rx_dispatch_pkg;

    localparam int OPC_W           = 5;
    localparam int NUM_OPC         = 32;
    localparam int OPC_LSB_DEFAULT = 24;
    // Wide enough for the largest supported channel count (8).
    localparam int ROUTE_CH_W      = 3;

    typedef struct packed {
        logic                  vld;
        logic [ROUTE_CH_W-1:0] ch;
    } route_t;

    localparam int ROUTE_W = $bits(route_t);

    // Request traffic goes to channel 0.
    localparam logic [NUM_OPC-1:0] DEF_CH0_MASK =
        (32'd1 << `OPC_SEND_FIRST) | (32'd1 << `OPC_SEND_MIDDLE) |
        (32'd1 << `OPC_SEND_LAST) | (32'd1 << `OPC_SEND_LAST_IMM) |
        (32'd1 << `OPC_SEND_ONLY) | (32'd1 << `OPC_SEND_ONLY_IMM) |
        (32'd1 << `OPC_RDMA_WRITE_FIRST) | (32'd1 << `OPC_RDMA_WRITE_MIDDLE) |
        (32'd1 << `OPC_RDMA_WRITE_LAST) | (32'd1 << `OPC_RDMA_WRITE_LAST_IMM) |
        (32'd1 << `OPC_RDMA_WRITE_ONLY) | (32'd1 << `OPC_RDMA_WRITE_ONLY_IMM) |
        (32'd1 << `OPC_RDMA_READ_REQUEST);

    // Response traffic goes to channel 1.
    localparam logic [NUM_OPC-1:0] DEF_CH1_MASK =
        (32'd1 << `OPC_RDMA_READ_RESPONSE_FIRST) | (32'd1 << `OPC_RDMA_READ_RESPONSE_MIDDLE) |
        (32'd1 << `OPC_RDMA_READ_RESPONSE_LAST) | (32'd1 << `OPC_RDMA_READ_RESPONSE_ONLY) |
        (32'd1 << `OPC_ACKNOWLEDGE);

    function automatic route_t default_route(input logic [OPC_W-1:0] opc);
        route_t r;
        r = '0;
        if (DEF_CH0_MASK[opc]) begin
            r.vld = 1'b1;
        end else if (DEF_CH1_MASK[opc]) begin
            r.vld = 1'b1;
            r.ch  = ROUTE_CH_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_dispatch_fifo.sv
// Per-channel packet head buffer for the RX dispatcher.
// Ports:
//   clk, rst               clock, synchronous active-high reset (empties buffer)
//   push, push_data        write request (ignored while full)
//   full                   occupancy == FIFO_DEPTH, from registered count only
//   out_valid, out_data    head of buffer; out_data is 0 while empty
//   out_ready              pops the head when out_valid is set

module rx_dispatch_fifo #(
    parameter int META_W     = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [META_W-1:0] push_data,
    output logic              full,
    output logic              out_valid,
    output logic [META_W-1:0] out_data,
    input  logic              out_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(FIFO_DEPTH);

    logic [META_W-1:0] mem_q [FIFO_DEPTH];
    logic [META_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    // One extra bit so a full buffer is distinguishable from an empty one.
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push, do_pop;

    assign full      = (count_q == CNT_MAX);
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign do_push   = push && !full;
    assign do_pop    = out_valid && out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the count alone decides what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rx_multi_dispatcher.sv
// Routes ingress packet heads to NUM_CH output channels by opcode.
// A 32-entry route table {vld, ch} maps each opcode to a channel. Entries that
// are invalid or point past NUM_CH are dropped and counted in drop_cnt.
// Ports:
//   clk, rst                                 clock, synchronous active-high reset
//   ingress_pkt_valid/head/ready             ingress handshake
//   ch_pkt_valid/head/ready                  per-channel egress handshakes
//   cfg_wr_en/opcode/data                    route table write, data = {vld, ch}
//   drop_cnt                                 saturating count of dropped beats
//   ch_pkt_cnt (RX_DISPATCH_STATS_EN only)   saturating per-channel pop counts
// Optional feature macro: RX_DISPATCH_STATS_EN.

module rx_multi_dispatcher
    import rx_dispatch_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int META_W     = `PKT_META_BUS_WIDTH,
    parameter int OPC_LSB    = OPC_LSB_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W      = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ingress_pkt_valid,
    input  logic [META_W-1:0]        ingress_pkt_head,
    output logic                     ingress_pkt_ready,
    output logic [NUM_CH-1:0]        ch_pkt_valid,
    output logic [NUM_CH*META_W-1:0] ch_pkt_head,
    input  logic [NUM_CH-1:0]        ch_pkt_ready,
    input  logic                     cfg_wr_en,
    input  logic [OPC_W-1:0]         cfg_wr_opcode,
    input  logic [CH_W:0]            cfg_wr_data,
    output logic [31:0]              drop_cnt
`ifdef RX_DISPATCH_STATS_EN
    ,
    output logic [NUM_CH*32-1:0]     ch_pkt_cnt
`endif
);

    route_t           route_q [NUM_OPC];
    route_t           route_d [NUM_OPC];
    logic [31:0]      drop_cnt_q, drop_cnt_d;
    logic [OPC_W-1:0] opc;
    route_t           ent;
    logic             drop, tgt_full, accept;
    logic [NUM_CH-1:0] push, full_v;

    assign opc      = ingress_pkt_head[OPC_LSB +: OPC_W];
    assign drop_cnt = drop_cnt_q;

    // Lookup reads the registered table, so a same-cycle write only affects
    // later beats.
    always_comb begin
        ent      = route_q[opc];
        drop     = !ent.vld || (int'(ent.ch) >= NUM_CH);
        tgt_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(ent.ch) == i) tgt_full = full_v[i];
        end
        ingress_pkt_ready = !rst && (drop || !tgt_full);
        accept            = ingress_pkt_valid && ingress_pkt_ready;
        push              = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            push[i] = accept && !drop && (int'(ent.ch) == i);
        end

        drop_cnt_d = drop_cnt_q;
        if (accept && drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end

        route_d = route_q;
        if (cfg_wr_en) begin
            route_d[cfg_wr_opcode].vld = cfg_wr_data[CH_W];
            route_d[cfg_wr_opcode].ch  = ROUTE_CH_W'(cfg_wr_data[CH_W-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OPC; i++) begin
                route_q[i] <= default_route(OPC_W'(i));
            end
            drop_cnt_q <= '0;
        end else begin
            route_q    <= route_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rx_dispatch_fifo #(
            .META_W     (META_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[g]),
            .push_data (ingress_pkt_head),
            .full      (full_v[g]),
            .out_valid (ch_pkt_valid[g]),
            .out_data  (ch_pkt_head[g*META_W +: META_W]),
            .out_ready (ch_pkt_ready[g])
        );
    end

`ifdef RX_DISPATCH_STATS_EN
    logic [31:0] pkt_cnt_q [NUM_CH];
    logic [31:0] pkt_cnt_d [NUM_CH];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            pkt_cnt_d[i] = pkt_cnt_q[i];
            if (ch_pkt_valid[i] && ch_pkt_ready[i] && (pkt_cnt_q[i] != '1)) begin
                pkt_cnt_d[i] = pkt_cnt_q[i] + 32'd1;
            end
            ch_pkt_cnt[i*32 +: 32] = pkt_cnt_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) pkt_cnt_q[i] <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end
`endif

endmodule
